// File: rtl/register_file_if.sv
// register_file_if: decode/writeback bus into the d16 register file.
//   master : drives stage enable, read addresses and both write ports;
//            receives the registered read data and the ready flag.
//   slave  : the register file side of the same signals.
interface register_file_if #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3
);
  logic                  en;
  logic [ADDR_WIDTH-1:0] rd_addr_a;
  logic [DATA_WIDTH-1:0] rd_data_a;
  logic [ADDR_WIDTH-1:0] rd_addr_b;
  logic [DATA_WIDTH-1:0] rd_data_b;
  logic                  wr_en_a;
  logic [ADDR_WIDTH-1:0] wr_addr_a;
  logic [DATA_WIDTH-1:0] wr_data_a;
  logic                  wr_en_b;
  logic [ADDR_WIDTH-1:0] wr_addr_b;
  logic [DATA_WIDTH-1:0] wr_data_b;
  logic                  ready;

  modport master (
    output en, rd_addr_a, rd_addr_b,
    output wr_en_a, wr_addr_a, wr_data_a,
    output wr_en_b, wr_addr_b, wr_data_b,
    input  rd_data_a, rd_data_b, ready
  );

  modport slave (
    input  en, rd_addr_a, rd_addr_b,
    input  wr_en_a, wr_addr_a, wr_data_a,
    input  wr_en_b, wr_addr_b, wr_data_b,
    output rd_data_a, rd_data_b, ready
  );
endinterface

// File: rtl/register_file.sv
// register_file: 2-read / 2-write register file for the d16 datapath.
//   clk  : clock, everything on posedge
//   rst  : synchronous active-high reset; restarts the clear sequence
//   bus  : register_file_if.slave (en, read ports A/B, write ports A/B, ready)
// After reset the array is zeroed one entry per cycle; ready rises once the
// last entry is cleared. Read data is registered; same-edge writes can be
// forwarded to the read ports (BYPASS) and register 0 can be hard-wired to
// zero (ZERO_REG). Write port B beats port A on an address conflict.

// Per-read-port next-data selection.
module register_file_rdport #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic [ADDR_WIDTH-1:0]                          addr_i,
  input  logic [(2**ADDR_WIDTH)-1:0][DATA_WIDTH-1:0]     regs_i,
  input  logic                                           we_a_i,
  input  logic [ADDR_WIDTH-1:0]                          wa_a_i,
  input  logic [DATA_WIDTH-1:0]                          wd_a_i,
  input  logic                                           we_b_i,
  input  logic [ADDR_WIDTH-1:0]                          wa_b_i,
  input  logic [DATA_WIDTH-1:0]                          wd_b_i,
  output logic [DATA_WIDTH-1:0]                          data_o
);
  always_comb begin
    data_o = regs_i[addr_i];
    if (BYPASS) begin
      // B is checked last so it wins, matching the storage priority.
      if (we_a_i && (wa_a_i == addr_i)) data_o = wd_a_i;
      if (we_b_i && (wa_b_i == addr_i)) data_o = wd_b_i;
    end
    if (ZERO_REG && (addr_i == '0)) data_o = '0;
  end
endmodule

module register_file #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 3,
  parameter bit ZERO_REG   = 1'b0,
  parameter bit BYPASS     = 1'b1
) (
  input  logic            clk,
  input  logic            rst,
  register_file_if.slave  bus
);
  localparam int NUM_REGS = 2**ADDR_WIDTH;
  localparam int NPORTS   = 2;
  localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(NUM_REGS - 1);

  typedef enum logic {S_CLEAR, S_RUN} state_e;

  state_e                                  state_q;
  logic [ADDR_WIDTH-1:0]                   clr_idx_q;
  logic                                    ready_q;
  logic [NUM_REGS-1:0][DATA_WIDTH-1:0]     regs_q;
  logic [NPORTS-1:0][DATA_WIDTH-1:0]       rd_q;
  logic [NPORTS-1:0][DATA_WIDTH-1:0]       rd_d;
  logic [NPORTS-1:0][ADDR_WIDTH-1:0]       rd_addr;
  logic                                    we_a, we_b;

  // Writes to r0 are dropped entirely when it is hard-wired, so they are
  // neither stored nor forwarded.
  assign we_a = bus.wr_en_a && !(ZERO_REG && (bus.wr_addr_a == '0));
  assign we_b = bus.wr_en_b && !(ZERO_REG && (bus.wr_addr_b == '0));

  assign rd_addr = {bus.rd_addr_b, bus.rd_addr_a};

  for (genvar p = 0; p < NPORTS; p++) begin : g_rd
    register_file_rdport #(
      .DATA_WIDTH (DATA_WIDTH),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ZERO_REG   (ZERO_REG),
      .BYPASS     (BYPASS)
    ) u_rdport (
      .addr_i (rd_addr[p]),
      .regs_i (regs_q),
      .we_a_i (we_a),
      .wa_a_i (bus.wr_addr_a),
      .wd_a_i (bus.wr_data_a),
      .we_b_i (we_b),
      .wa_b_i (bus.wr_addr_b),
      .wd_b_i (bus.wr_data_b),
      .data_o (rd_d[p])
    );
  end

  // The array itself is not reset: the clear sequencer owns zeroing it.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_CLEAR;
      clr_idx_q <= '0;
      ready_q   <= 1'b0;
      rd_q      <= '0;
    end else begin
      case (state_q)
        S_CLEAR: begin
          regs_q[clr_idx_q] <= '0;
          clr_idx_q         <= clr_idx_q + ADDR_WIDTH'(1);
          rd_q              <= '0;
          if (clr_idx_q == LAST_IDX) begin
            state_q <= S_RUN;
            ready_q <= 1'b1;
          end
        end
        S_RUN: begin
          if (bus.en) begin
            rd_q <= rd_d;
            if (we_a) regs_q[bus.wr_addr_a] <= bus.wr_data_a;
            if (we_b) regs_q[bus.wr_addr_b] <= bus.wr_data_b;
          end
        end
        default: state_q <= S_CLEAR;
      endcase
    end
  end

  assign bus.rd_data_a = rd_q[0];
  assign bus.rd_data_b = rd_q[1];
  assign bus.ready     = ready_q;
endmodule
